// File: rtl/w_stage_grf.sv
// rtl/w_stage_grf.sv - writeback stage: result select plus 32x32 register file with write-before-read bypass
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   RegWriteW                  write enable from the M/W pipeline register
//   MemtoRegW[1:0]             writeback source: 00 ALU, 01 load, 10 PC+8 link, 11 immediate
//   RDW, ALUoutW, PC_4W,
//   ext_immW [31:0]            candidate writeback values
//   WriteRegW[4:0]             destination register index
//   A1, A2 [4:0]               decode-stage read addresses
//   RD1, RD2 [31:0]            read data, bypassed from the in-flight write
//   WD3 [31:0], WE3            selected write data and effective write enable, exported for forwarding

module w_stage_grf (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteW,
    input  logic [1:0]  MemtoRegW,
    input  logic [31:0] RDW,
    input  logic [31:0] ALUoutW,
    input  logic [4:0]  WriteRegW,
    input  logic [31:0] PC_4W,
    input  logic [31:0] ext_immW,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    output logic [31:0] RD1,
    output logic [31:0] RD2,
    output logic [31:0] WD3,
    output logic        WE3
);

    logic [31:0] regs [32];

    // PC_4W already holds PC+4; the link address for jal/jalr is PC+8.
    always_comb begin
        WD3 = ALUoutW;
        case (MemtoRegW)
            2'b00:   WD3 = ALUoutW;
            2'b01:   WD3 = RDW;
            2'b10:   WD3 = PC_4W + 32'd4;
            default: WD3 = ext_immW;
        endcase
    end

    // Writes to $0 are squashed here so forwarding logic never sees them.
    assign WE3 = RegWriteW && (WriteRegW != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (WE3) begin
            regs[WriteRegW] <= WD3;
        end
    end

    // The value being written this cycle is visible to decode immediately,
    // so no separate half-cycle register-file trick is needed.
    always_comb begin
        RD1 = regs[A1];
        if (A1 == 5'd0) begin
            RD1 = 32'd0;
        end else if (WE3 && (A1 == WriteRegW)) begin
            RD1 = WD3;
        end
    end

    always_comb begin
        RD2 = regs[A2];
        if (A2 == 5'd0) begin
            RD2 = 32'd0;
        end else if (WE3 && (A2 == WriteRegW)) begin
            RD2 = WD3;
        end
    end

endmodule
